if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect priority and IF/ID latch.
// Also synchronises the external interrupt line for Control.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic [31:0] id_rs_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        irq_in,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        Supervised,
  output logic        IRQ
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  if_id_t      if_id_q;
  if_id_t      if_id_d;
  logic        sync1_q;
  logic        sync2_q;
  logic        irq_sync;

  logic [31:0] pc4;
  logic [31:0] jmp_tgt;
  logic [31:0] jr_tgt;

  logic sel_br;
  logic sel_irq;
  logic sel_exc;
  logic sel_hold;
  logic sel_jmp;
  logic sel_jr;
  logic sel_seq;

  // Exclusive selects encoding the redirect priority order
  always_comb begin
    sel_br   = branch_taken;
    sel_irq  = ~sel_br & (PCSrc == 3'b011);
    sel_exc  = ~sel_br & (PCSrc == 3'b100);
    sel_hold = ~sel_br & ~sel_irq
             & ~sel_exc & stall;
    sel_jmp  = ~sel_br & ~stall
             & (PCSrc == 3'b001);
    sel_jr   = ~sel_br & ~stall
             & (PCSrc == 3'b010);
    sel_seq  = ~(sel_br | sel_irq | sel_exc
             | sel_hold | sel_jmp | sel_jr);
  end

  // Next PC and next IF/ID slot
  always_comb begin
    pc4     = pc_q + 32'd4;
    jmp_tgt = {if_id_q.pc4[31:28],
               if_id_q.instr[25:0], 2'b00};
    jr_tgt  = {id_rs_data[31:2], 2'b00};
    pc_d    = pc_q;
    if_id_d = if_id_q;
    unique case (1'b1)
      sel_br: begin
        pc_d    = branch_target;
        if_id_d = '0;
      end
      sel_irq: begin
        pc_d    = IRQ_VEC;
        if_id_d = '0;
      end
      sel_exc: begin
        pc_d    = EXC_VEC;
        if_id_d = '0;
      end
      sel_hold: begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
      end
      sel_jmp: begin
        pc_d    = jmp_tgt;
        if_id_d = '0;
      end
      sel_jr: begin
        pc_d    = jr_tgt;
        if_id_d = '0;
      end
      sel_seq: begin
        pc_d          = pc4;
        if_id_d.instr = imem_rdata;
        if_id_d.pc4   = pc4;
        if_id_d.valid = 1'b1;
      end
      default: begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
      end
    endcase
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      if_id_q <= '0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  // Two-flop interrupt synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  // Outputs; bubbles count as supervisor so they never trap
  always_comb begin
    irq_sync    = sync2_q;
    imem_addr   = pc_q;
    id_instr    = if_id_q.instr;
    id_pc_plus4 = if_id_q.pc4;
    id_valid    = if_id_q.valid;
    Supervised  = if_id_q.valid
                ? if_id_q.pc4[31] : 1'b1;
    IRQ         = irq_sync & if_id_q.valid
                & ~Supervised;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, redirects, stall,
// interrupt sync, PC wrap and async reset.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [2:0]  PCSrc;
  logic [31:0] id_rs_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        irq_in;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        Supervised;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PCSrc        (PCSrc),
    .id_rs_data   (id_rs_data),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .irq_in       (irq_in),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .id_valid     (id_valid),
    .Supervised   (Supervised),
    .IRQ          (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: j 0x0100000 at 80000010, else ~address
  function automatic logic [31:0] mem(
    input logic [31:0] a);
    if (a == 32'h8000_0010) return 32'h0810_0000;
    return ~a;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_instr"}, id_instr, 32'd0);
    chk({tag, "_pc4"}, id_pc_plus4, 32'd0);
    chk({tag, "_sup"}, {31'd0, Supervised}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp_pc;
    reset         = 1'b1;
    PCSrc         = 3'b000;
    id_rs_data    = 32'd0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    stall         = 1'b0;
    irq_in        = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_pc", imem_addr, 32'h8000_0000);
    chk_bubble("rst");
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    tick();
    chk("rst_hold_pc", imem_addr, 32'h8000_0000);
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch
    exp_pc = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("seq_pc4", id_pc_plus4, exp_pc + 32'd4);
      chk("seq_instr", id_instr, mem(exp_pc));
      chk("seq_valid", {31'd0, id_valid}, 32'd1);
      exp_pc = exp_pc + 32'd4;
      chk("seq_pc", imem_addr, exp_pc);
    end
    chk("seq_sup", {31'd0, Supervised}, 32'd1);

    // Jump from slot with pc4=80000014
    PCSrc = 3'b001;
    tick();
    chk("j_pc", imem_addr, 32'h8040_0000);
    chk_bubble("j");
    PCSrc = 3'b000;

    // jr held by stall for two cycles
    id_rs_data = 32'h0040_0007;
    PCSrc      = 3'b010;
    stall      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("jrs_pc", imem_addr, 32'h8040_0000);
      chk("jrs_valid", {31'd0, id_valid}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("jr_pc", imem_addr, 32'h0040_0004);
    chk_bubble("jr");
    PCSrc = 3'b000;
    tick();
    chk("jr_fetch_pc4", id_pc_plus4, 32'h0040_0008);
    chk("jr_fetch_sup", {31'd0, Supervised}, 32'd0);

    // Stall with a valid slot holds everything
    stall = 1'b1;
    tick();
    chk("stall_pc", imem_addr, 32'h0040_0008);
    chk("stall_pc4", id_pc_plus4, 32'h0040_0008);
    chk("stall_valid", {31'd0, id_valid}, 32'd1);

    // Branch beats exception and stall
    branch_taken  = 1'b1;
    branch_target = 32'h0040_0100;
    PCSrc         = 3'b100;
    tick();
    chk("bvt_pc", imem_addr, 32'h0040_0100);
    chk_bubble("bvt");
    branch_taken = 1'b0;

    // Exception beats stall
    tick();
    chk("exc_pc", imem_addr, 32'h8000_0008);
    chk_bubble("exc");
    stall = 1'b0;

    // Reserved PCSrc acts as sequential
    PCSrc = 3'b110;
    tick();
    chk("rsv_pc", imem_addr, 32'h8000_000C);
    chk("rsv_pc4", id_pc_plus4, 32'h8000_000C);
    chk("rsv_valid", {31'd0, id_valid}, 32'd1);
    PCSrc = 3'b000;

    // Put user instruction (pc4=00400010) in ID
    branch_taken  = 1'b1;
    branch_target = 32'h0040_000C;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("usr_pc4", id_pc_plus4, 32'h0040_0010);
    chk("usr_sup", {31'd0, Supervised}, 32'd0);

    // Interrupt through the synchroniser
    stall  = 1'b1;
    irq_in = 1'b1;
    #1;
    chk("irq_pre", {31'd0, IRQ}, 32'd0);
    tick();
    chk("irq_e0", {31'd0, IRQ}, 32'd0);
    tick();
    chk("irq_e1", {31'd0, IRQ}, 32'd1);
    PCSrc = 3'b011;
    tick();
    chk("irq_pc", imem_addr, 32'h8000_0004);
    chk_bubble("irq");
    chk("irq_bub", {31'd0, IRQ}, 32'd0);
    PCSrc = 3'b000;
    stall = 1'b0;
    tick();
    chk("irq_kern_pc4", id_pc_plus4, 32'h8000_0008);
    chk("irq_kern", {31'd0, IRQ}, 32'd0);
    irq_in = 1'b0;

    // PC wrap
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    tick();
    chk("wrap_pc", imem_addr, 32'h0000_0000);
    chk("wrap_pc4", id_pc_plus4, 32'h0000_0000);
    chk("wrap_instr", id_instr, 32'h0000_0003);
    chk("wrap_valid", {31'd0, id_valid}, 32'd1);

    // Async reset between edges, mid-stall
    stall = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", imem_addr, 32'h8000_0000);
    chk_bubble("arst");
    chk("arst_irq", {31'd0, IRQ}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
